// File: rtl/motion_compensator.sv
// rtl/motion_compensator.sv - fetches a motion-compensated 16x16 block, adds residuals, saturates and streams it out
module motion_compensator #(
    parameter int ROW_STRIDE = 32,
    parameter int MV_X_BIAS  = 8,
    parameter int MV_Y_BIAS  = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] motionX,
    input  logic [3:0] motionY,
    output logic [9:0] AddressS,
    input  logic [7:0] S,
    output logic [7:0] AddressRes,
    input  logic [8:0] residual,
    output logic [7:0] out_pixel,
    output logic [7:0] out_index,
    output logic       out_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       completed
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [7:0]        count;
    logic [3:0]        off_x;
    logic [3:0]        off_y;
    logic [4:0]        row_sum;
    logic [4:0]        col_sum;
    logic signed [9:0] sum;
    logic [7:0]        sat_pixel;
    logic              adv;

    // Offsets are 4-bit and the block is 16 wide, so the 5-bit sums stay below 31.
    assign row_sum = {1'b0, off_y} + {1'b0, count[7:4]};
    assign col_sum = {1'b0, off_x} + {1'b0, count[3:0]};
    assign adv     = !out_valid || out_ready;
    assign busy    = (state != IDLE);

    // count parks at 255 in DONE, so the addresses naturally hold their last value there.
    always_comb begin
        AddressS   = '0;
        AddressRes = '0;
        if (state != IDLE) begin
            AddressS   = 10'(row_sum * ROW_STRIDE) + 10'(col_sum);
            AddressRes = count;
        end
    end

    assign sum = $signed({2'b00, S}) + $signed({residual[8], residual});

    always_comb begin
        sat_pixel = sum[7:0];
        if (sum[9]) begin
            sat_pixel = 8'h00;
        end else if (sum[8]) begin
            sat_pixel = 8'hFF;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 8'd0;
            off_x     <= 4'd0;
            off_y     <= 4'd0;
            out_valid <= 1'b0;
            out_pixel <= 8'd0;
            out_index <= 8'd0;
            out_last  <= 1'b0;
            completed <= 1'b0;
        end else begin
            completed <= 1'b0;
            case (state)
                IDLE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (start) begin
                        off_x <= motionX + 4'(MV_X_BIAS);
                        off_y <= motionY + 4'(MV_Y_BIAS);
                        count <= 8'd0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (adv) begin
                        out_pixel <= sat_pixel;
                        out_index <= count;
                        out_last  <= (count == 8'hFF);
                        out_valid <= 1'b1;
                        if (count == 8'hFF) begin
                            state <= DONE;
                        end else begin
                            count <= count + 8'd1;
                        end
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        completed <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motion_compensator.sv
// tb/tb_motion_compensator.sv - randomized self-checking bench for motion_compensator
module tb_motion_compensator;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] motionX;
    logic [3:0] motionY;
    logic [9:0] AddressS;
    logic [7:0] S;
    logic [7:0] AddressRes;
    logic [8:0] residual;
    logic [7:0] out_pixel;
    logic [7:0] out_index;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       completed;

    logic [7:0] smem [1024];
    logic [8:0] resmem [256];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got_pix [256];
    logic [7:0] got_idx [256];
    logic       got_last [256];
    logic [9:0] got_addr [256];
    logic [7:0] got_ares [256];
    logic [9:0] stall_addr [5];
    logic [7:0] stall_pix [5];
    logic [7:0] stall_idx [5];
    int nhs, naddr, comp_cycle, comp_count, first_valid, busy_cnt, nstall;
    bit timeout, aborted;

    motion_compensator dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .motionX   (motionX),
        .motionY   (motionY),
        .AddressS  (AddressS),
        .S         (S),
        .AddressRes(AddressRes),
        .residual  (residual),
        .out_pixel (out_pixel),
        .out_index (out_index),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .completed (completed)
    );

    always #5 clock = ~clock;

    assign S        = smem[AddressS];
    assign residual = resmem[AddressRes];

    // Reference: block origin from the biased vector, then clamp(S + signed residual).
    function automatic int ref_addr(input logic [3:0] mx, input logic [3:0] my, input int k);
        int x, y;
        x = (int'(mx) + 8) % 16;
        y = (int'(my) + 9) % 16;
        return (y + k / 16) * 32 + x + k % 16;
    endfunction

    function automatic int ref_pix(input logic [3:0] mx, input logic [3:0] my, input int k);
        int r, v;
        r = int'(resmem[k]);
        if (r >= 256) r = r - 512;
        v = int'(smem[ref_addr(mx, my, k)]) + r;
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 1024; i++) smem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) resmem[i] = 9'($urandom);
    endtask

    // Drives one block and records what the DUT emits; comparisons are done by the callers.
    // mode 0: ready=1, 1: stall 5 cycles at index 3, 2: random ready, 3: abort at index 100.
    task automatic run_block(input bit launch, input logic [3:0] mx, input logic [3:0] my,
                             input int mode, input bit poke, input bit chain,
                             input logic [3:0] nx, input logic [3:0] ny);
        int stalled;
        stalled = 0;
        nhs = 0; naddr = 0; comp_cycle = -1; comp_count = 0; first_valid = -1;
        busy_cnt = 0; nstall = 0; timeout = 1; aborted = 0;
        if (launch) begin
            start = 1'b1; motionX = mx; motionY = my;
        end
        @(posedge clock); #1;
        start = 1'b0; motionX = 4'($urandom); motionY = 4'($urandom);
        for (int n = 0; n < 4000; n++) begin
            start = 1'b0;
            case (mode)
                1: begin
                    out_ready = 1'b1;
                    if (out_valid && out_index == 8'd3 && stalled < 5) begin
                        out_ready = 1'b0;
                        stall_addr[stalled] = AddressS;
                        stall_pix[stalled]  = out_pixel;
                        stall_idx[stalled]  = out_index;
                        stalled++;
                        nstall = stalled;
                    end
                end
                2: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
            if (mode == 3 && out_valid && out_index == 8'd100) begin
                aborted = 1; timeout = 0;
                break;
            end
            if (out_valid && first_valid < 0) first_valid = n;
            if (busy) busy_cnt++;
            if (busy && (!out_valid || out_ready) && naddr < 256) begin
                got_addr[naddr] = AddressS;
                got_ares[naddr] = AddressRes;
                naddr++;
            end
            if (out_valid && out_ready) begin
                if (nhs < 256) begin
                    got_pix[nhs] = out_pixel; got_idx[nhs] = out_index; got_last[nhs] = out_last;
                end
                nhs++;
            end
            if (completed) begin
                comp_count++;
                if (comp_cycle < 0) comp_cycle = n;
            end
            if (poke && n >= 10 && n <= 12) begin
                start = 1'b1; motionX = nx; motionY = ny;
            end
            if (completed && chain) begin
                start = 1'b1; motionX = nx; motionY = ny; timeout = 0;
                break;
            end
            if (comp_cycle >= 0 && n >= comp_cycle + 3) begin
                timeout = 0;
                break;
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; motionX = 4'd0; motionY = 4'd0; out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || completed !== 1'b0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got valid=%b busy=%b comp=%b last=%b exp all 0", out_valid, busy, completed, out_last);
        end
        n_checks++;
        if (out_pixel !== 8'd0 || out_index !== 8'd0 || AddressS !== 10'd0 || AddressRes !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_data got pix=%0d idx=%0d adS=%0d adR=%0d exp all 0", out_pixel, out_index, AddressS, AddressRes);
        end
        reset = 1'b0;
    endtask

    task automatic test_identity();
        for (int i = 0; i < 1024; i++) smem[i] = 8'(i);
        for (int i = 0; i < 256; i++) resmem[i] = 9'd0;
        run_block(1, 4'h8, 4'h7, 0, 0, 0, 4'h0, 4'h0);
        n_checks++;
        if (timeout || nhs != 256 || naddr != 256) begin
            n_fail++;
            $display("FAIL identity_count got timeout=%0d nhs=%0d naddr=%0d exp 0/256/256", timeout, nhs, naddr);
        end
        for (int k = 0; k < 256; k++) begin
            int a;
            a = (k >> 4) * 32 + (k & 15);
            n_checks++;
            if (got_idx[k] !== 8'(k) || got_pix[k] !== 8'(a & 255) || got_last[k] !== (k == 255)
                || got_addr[k] !== 10'(a) || got_ares[k] !== 8'(k)) begin
                n_fail++;
                $display("FAIL identity_k%0d got idx=%0d pix=%0d last=%b adS=%0d adR=%0d exp %0d/%0d/%b/%0d/%0d",
                         k, got_idx[k], got_pix[k], got_last[k], got_addr[k], got_ares[k], k, a & 255, k == 255, a, k);
            end
        end
        n_checks++;
        if (first_valid != 1 || comp_cycle != 257 || comp_count != 1 || busy_cnt != 257) begin
            n_fail++;
            $display("FAIL identity_latency got first_valid=%0d comp=%0d ncomp=%0d busy=%0d exp 1/257/1/257",
                     first_valid, comp_cycle, comp_count, busy_cnt);
        end
    endtask

    task automatic test_corner();
        fill_random();
        run_block(1, 4'h7, 4'h6, 0, 0, 0, 4'h0, 4'h0);
        n_checks++;
        if (timeout || nhs != 256 || got_addr[0] !== 10'd495 || got_addr[255] !== 10'd990) begin
            n_fail++;
            $display("FAIL corner_addr got timeout=%0d nhs=%0d first=%0d last=%0d exp 0/256/495/990",
                     timeout, nhs, got_addr[0], got_addr[255]);
        end
        for (int k = 0; k < 256; k++) begin
            n_checks++;
            if (got_idx[k] !== 8'(k) || got_pix[k] !== 8'(ref_pix(4'h7, 4'h6, k))) begin
                n_fail++;
                $display("FAIL corner_k%0d got idx=%0d pix=%0d exp %0d/%0d", k, got_idx[k], got_pix[k], k, ref_pix(4'h7, 4'h6, k));
            end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] s_tab [5];
        logic [8:0] r_tab [5];
        logic [7:0] e_tab [5];
        s_tab = '{8'd250, 8'd5, 8'd100, 8'd0, 8'd128};
        r_tab = '{9'd10, 9'h1EC, 9'h100, 9'd255, 9'h1FF};
        e_tab = '{8'd255, 8'd0, 8'd0, 8'd255, 8'd127};
        fill_random();
        for (int i = 0; i < 5; i++) begin
            smem[i] = s_tab[i]; resmem[i] = r_tab[i];
        end
        run_block(1, 4'h8, 4'h7, 0, 0, 0, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (got_pix[i] !== e_tab[i]) begin
                n_fail++;
                $display("FAIL sat_pair%0d got %0d exp %0d", i, got_pix[i], e_tab[i]);
            end
        end
        for (int k = 0; k < 256; k++) begin
            n_checks++;
            if (got_pix[k] !== 8'(ref_pix(4'h8, 4'h7, k))) begin
                n_fail++;
                $display("FAIL sat_k%0d got %0d exp %0d", k, got_pix[k], ref_pix(4'h8, 4'h7, k));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] mx, my;
        mx = 4'($urandom); my = 4'($urandom);
        fill_random();
        run_block(1, mx, my, 1, 0, 0, 4'h0, 4'h0);
        n_checks++;
        if (nstall != 5) begin
            n_fail++;
            $display("FAIL bp_stalls got %0d exp 5", nstall);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (stall_idx[i] !== 8'd3 || stall_pix[i] !== 8'(ref_pix(mx, my, 3)) || stall_addr[i] !== 10'(ref_addr(mx, my, 4))) begin
                n_fail++;
                $display("FAIL bp_hold%0d got idx=%0d pix=%0d adS=%0d exp 3/%0d/%0d",
                         i, stall_idx[i], stall_pix[i], stall_addr[i], ref_pix(mx, my, 3), ref_addr(mx, my, 4));
            end
        end
        n_checks++;
        if (timeout || nhs != 256 || comp_cycle != 262 || comp_count != 1) begin
            n_fail++;
            $display("FAIL bp_done got timeout=%0d nhs=%0d comp=%0d ncomp=%0d exp 0/256/262/1", timeout, nhs, comp_cycle, comp_count);
        end
        for (int k = 0; k < 256; k++) begin
            n_checks++;
            if (got_idx[k] !== 8'(k) || got_pix[k] !== 8'(ref_pix(mx, my, k))) begin
                n_fail++;
                $display("FAIL bp_k%0d got idx=%0d pix=%0d exp %0d/%0d", k, got_idx[k], got_pix[k], k, ref_pix(mx, my, k));
            end
        end
    endtask

    task automatic test_random_ready();
        for (int it = 0; it < 3; it++) begin
            logic [3:0] mx, my;
            mx = 4'($urandom); my = 4'($urandom);
            fill_random();
            run_block(1, mx, my, 2, 0, 0, 4'h0, 4'h0);
            n_checks++;
            if (timeout || nhs != 256 || comp_count != 1) begin
                n_fail++;
                $display("FAIL rand%0d_count got timeout=%0d nhs=%0d ncomp=%0d exp 0/256/1", it, timeout, nhs, comp_count);
            end
            for (int k = 0; k < 256; k++) begin
                n_checks++;
                if (got_idx[k] !== 8'(k) || got_pix[k] !== 8'(ref_pix(mx, my, k)) || got_last[k] !== (k == 255)) begin
                    n_fail++;
                    $display("FAIL rand%0d_k%0d got idx=%0d pix=%0d last=%b exp %0d/%0d/%b",
                             it, k, got_idx[k], got_pix[k], got_last[k], k, ref_pix(mx, my, k), k == 255);
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [3:0] mx, my;
        mx = 4'($urandom); my = 4'($urandom);
        fill_random();
        run_block(1, mx, my, 0, 1, 0, mx ^ 4'h5, my ^ 4'hA);
        n_checks++;
        if (timeout || nhs != 256 || comp_count != 1 || comp_cycle != 257) begin
            n_fail++;
            $display("FAIL ign_count got timeout=%0d nhs=%0d ncomp=%0d comp=%0d exp 0/256/1/257", timeout, nhs, comp_count, comp_cycle);
        end
        for (int k = 0; k < 256; k++) begin
            n_checks++;
            if (got_idx[k] !== 8'(k) || got_pix[k] !== 8'(ref_pix(mx, my, k))) begin
                n_fail++;
                $display("FAIL ign_k%0d got idx=%0d pix=%0d exp %0d/%0d", k, got_idx[k], got_pix[k], k, ref_pix(mx, my, k));
            end
        end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL ign_second_block got busy=%b valid=%b exp 0/0", busy, out_valid);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] m1x, m1y, m2x, m2y;
        m1x = 4'($urandom); m1y = 4'($urandom);
        m2x = 4'($urandom); m2y = 4'($urandom);
        fill_random();
        run_block(1, m1x, m1y, 0, 0, 1, m2x, m2y);
        n_checks++;
        if (timeout || nhs != 256 || comp_cycle != 257) begin
            n_fail++;
            $display("FAIL b2b_first got timeout=%0d nhs=%0d comp=%0d exp 0/256/257", timeout, nhs, comp_cycle);
        end
        run_block(0, m2x, m2y, 0, 0, 0, 4'h0, 4'h0);
        n_checks++;
        if (timeout || nhs != 256 || first_valid != 1 || comp_count != 1) begin
            n_fail++;
            $display("FAIL b2b_second got timeout=%0d nhs=%0d first_valid=%0d ncomp=%0d exp 0/256/1/1",
                     timeout, nhs, first_valid, comp_count);
        end
        for (int k = 0; k < 256; k++) begin
            n_checks++;
            if (got_idx[k] !== 8'(k) || got_pix[k] !== 8'(ref_pix(m2x, m2y, k))) begin
                n_fail++;
                $display("FAIL b2b_k%0d got idx=%0d pix=%0d exp %0d/%0d", k, got_idx[k], got_pix[k], k, ref_pix(m2x, m2y, k));
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [3:0] mx, my;
        fill_random();
        run_block(1, 4'($urandom), 4'($urandom), 3, 0, 0, 4'h0, 4'h0);
        n_checks++;
        if (!aborted) begin
            n_fail++;
            $display("FAIL midreset_reach got aborted=%0d exp 1", aborted);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || completed !== 1'b0 || AddressS !== 10'd0) begin
            n_fail++;
            $display("FAIL midreset_state got valid=%b busy=%b comp=%b adS=%0d exp 0/0/0/0", out_valid, busy, completed, AddressS);
        end
        mx = 4'($urandom); my = 4'($urandom);
        run_block(1, mx, my, 0, 0, 0, 4'h0, 4'h0);
        n_checks++;
        if (timeout || nhs != 256 || comp_count != 1 || got_idx[0] !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_restart got timeout=%0d nhs=%0d ncomp=%0d idx0=%0d exp 0/256/1/0",
                     timeout, nhs, comp_count, got_idx[0]);
        end
        for (int k = 0; k < 256; k++) begin
            n_checks++;
            if (got_idx[k] !== 8'(k) || got_pix[k] !== 8'(ref_pix(mx, my, k))) begin
                n_fail++;
                $display("FAIL midreset_k%0d got idx=%0d pix=%0d exp %0d/%0d", k, got_idx[k], got_pix[k], k, ref_pix(mx, my, k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_corner();
        test_saturation();
        test_backpressure();
        test_random_ready();
        test_start_ignored();
        test_back_to_back();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/motion_compensator.md
Name: motion_compensator

Overview:
- Decoder-side counterpart of the full-search motion estimator: takes a motion vector (motionX/motionY, same 4-bit encoding the estimator produces) and fetches the matching 16x16 predicted block from the search-window memory.
- Adds a signed residual per pixel, saturates to 8 bits, and streams the reconstructed block out in raster order with a valid/ready handshake.
- Connects to the existing search memory (combinational read, 32-pixel row stride) and to a residual memory indexed like the reference block.

Parameters:
- ROW_STRIDE, 32, search-memory pixels per row; address = row*ROW_STRIDE + col.
- MV_X_BIAS, 8, horizontal offset x = (motionX + MV_X_BIAS) mod 16.
- MV_Y_BIAS, 9, vertical offset y = (motionY + MV_Y_BIAS) mod 16.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a block; sampled only in IDLE.
- motionX  in  4  motion vector X, latched on accepted start.
- motionY  in  4  motion vector Y, latched on accepted start.
- AddressS  out  10  search-memory read address, combinational from state/count.
- S  in  8  search-memory data for AddressS, same cycle.
- AddressRes  out  8  residual-memory address, equal to the current pixel index.
- residual  in  9  two's-complement residual for AddressRes, same cycle (-256..255).
- out_pixel  out  8  reconstructed pixel.
- out_index  out  8  raster index of out_pixel (row*16+col).
- out_last  out  1  high with index 255.
- out_valid  out  1  out_pixel/out_index/out_last valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- busy  out  1  high whenever state != IDLE.
- completed  out  1  one-cycle pulse after the final pixel handshake.

Behaviour:
- Reset (sync, highest priority, any state): state IDLE, count 0, out_valid 0, out_pixel 0, out_index 0, out_last 0, completed 0, latched offsets 0. Reset mid-block abandons the block with no completed pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1: latch x = motionX+MV_X_BIAS and y = motionY+MV_Y_BIAS (4-bit wrap), set count=0, go to RUN.
  - completed deasserts after its single cycle.
- RUN:
  - r = count[7:4], c = count[3:0].
  - AddressS = (y+r)*ROW_STRIDE + (x+c). The 5-bit row/column sums never wrap; max address is 990.
  - AddressRes = count.
  - Advance condition: adv = !out_valid || out_ready.
  - When adv: capture out_pixel = clamp({2'b00,S} + sign-extended residual, 0, 255) using 10-bit signed arithmetic. Also set out_index=count, out_last=(count==255), out_valid=1, count=count+1. If count==255, go to DONE.
  - When !adv: hold count, AddressS, AddressRes and the output registers.
- DONE:
  - AddressS and AddressRes hold their last values.
  - On out_valid && out_ready: out_valid=0, completed=1 next cycle, go to IDLE.
- Outside RUN, out_valid drops only on a handshake.
- Outside RUN/DONE, AddressS=0 and AddressRes=0.
- start is ignored in RUN and DONE.
- Back-to-back operation: start may be accepted in the same cycle completed is high.
- Latency with out_ready=1 and start accepted at t0:
  - Captures occur t0+1..t0+256.
  - out_valid is high t0+2..t0+257.
  - completed pulses at t0+258.
  - busy is high t0+1..t0+257.
- Each pixel index 0..255 is emitted exactly once, in order, regardless of stalls.

Test Plan:
- Identity fetch: Smem[a]=a[7:0], residual=0, motionX=4'h8, motionY=4'h7 (x=y=0), out_ready=1, start at t0 -> AddressS sequence 0..15, 32..47, ... 495. Pixel k = ((k>>4)*32+(k&15))&8'hFF. out_last with index 255 at t0+257. completed single pulse at t0+258.
- Corner offset: motionX=4'h7, motionY=4'h6 (x=y=15) -> first AddressS 495, last AddressS 990, index/pixel order intact.
- Saturation, each pair (S, residual) -> out_pixel:
  - (250, +10) -> 255.
  - (5, 9'h1EC = -20) -> 0.
  - (100, 9'h100 = -256) -> 0.
  - (0, +255) -> 255.
  - (128, -1) -> 127.
- Backpressure: out_ready=0 for 5 cycles while out_index=3 -> out_pixel/out_index held at 3. AddressS stays at the index-4 address. No duplicate or lost index. completed delayed exactly 5 cycles.
- Start ignored: start pulses in RUN with a different vector -> output stream and vector unchanged, no second block. Start in the cycle completed=1 -> new block begins, first out_valid 2 cycles later.
- Reset mid-run at out_index=100 -> next cycle out_valid=0, busy=0, completed=0, AddressS=0. A subsequent start restarts at index 0 with a fresh vector.
